// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer feeding a registered instruction ROM.
// Tracks the PC held in the ROM output register and applies decode redirects.
module fetch_pc_unit #(
    parameter int PC_W      = 32,
    parameter int ROM_DEPTH = 16,
    parameter int RESET_PC  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic signed [15:0]  branch_offset,
    input  logic                jump_en,
    input  logic [25:0]         jump_target,
    output logic [PC_W-1:0]     index,
    output logic                instr_valid,
    output logic [PC_W-1:0]     instr_pc,
    output logic                redirect,
    output logic [31:0]         fetch_count
);

    localparam logic [PC_W-1:0] IDX_MASK = PC_W'(ROM_DEPTH - 1);
    localparam logic [PC_W-1:0] PC_RST   = PC_W'(RESET_PC);

    // Branch target relative to the instruction after the branch, wrapping in PC_W bits.
    function automatic logic [PC_W-1:0] branch_tgt(input logic [PC_W-1:0] base,
                                                   input logic signed [15:0] off);
        logic signed [PC_W-1:0] off_ext;
        off_ext = PC_W'(off);
        return base + PC_W'(1) + $unsigned(off_ext);
    endfunction

    logic [PC_W-1:0] pc_p0, pc_nx;
    logic [PC_W-1:0] instr_pc_p1, instr_pc_nx;
    logic            vld_p1, vld_nx;
    logic [31:0]     cnt_p1, cnt_nx;
    logic [PC_W-1:0] fetch_sel;

    // stage p0: fetch address selection and redirect decision
    always_comb begin
        fetch_sel = stall ? instr_pc_p1 : pc_p0;
        index     = fetch_sel & IDX_MASK;
        redirect  = vld_p1 & ~stall & (branch_taken | jump_en);
    end

    always_comb begin
        pc_nx       = pc_p0;
        instr_pc_nx = instr_pc_p1;
        vld_nx      = vld_p1;
        cnt_nx      = cnt_p1;
        if (stall) begin
            // hold everything; the ROM re-reads instr_pc
        end else if (redirect) begin
            // the sequential word latched at this edge is squashed
            pc_nx       = jump_en ? PC_W'(jump_target) : branch_tgt(instr_pc_p1, branch_offset);
            instr_pc_nx = pc_p0;
            vld_nx      = 1'b0;
        end else begin
            pc_nx       = pc_p0 + PC_W'(1);
            instr_pc_nx = pc_p0;
            vld_nx      = 1'b1;
            cnt_nx      = cnt_p1 + 32'd1;
        end
    end

    // stage p1: state aligned with the ROM's InstrReg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0       <= PC_RST;
            instr_pc_p1 <= '0;
            vld_p1      <= 1'b0;
            cnt_p1      <= '0;
        end else begin
            pc_p0       <= pc_nx;
            instr_pc_p1 <= instr_pc_nx;
            vld_p1      <= vld_nx;
            cnt_p1      <= cnt_nx;
        end
    end

    assign instr_valid = vld_p1;
    assign instr_pc    = instr_pc_p1;
    assign fetch_count = cnt_p1;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed scenarios plus random stimulus.
module tb_fetch_pc_unit;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               stall;
    logic               branch_taken;
    logic signed [15:0] branch_offset;
    logic               jump_en;
    logic [25:0]        jump_target;
    logic [31:0]        index;
    logic               instr_valid;
    logic [31:0]        instr_pc;
    logic               redirect;
    logic [31:0]        fetch_count;

    fetch_pc_unit #(.PC_W(32), .ROM_DEPTH(16), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump_en(jump_en), .jump_target(jump_target),
        .index(index), .instr_valid(instr_valid), .instr_pc(instr_pc),
        .redirect(redirect), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ipc;
        logic        vld;
        logic [31:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc, m_ipc, m_cnt;
    logic        m_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_ipc = 32'd0; m_vld = 1'b0; m_cnt = 32'd0;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic st, input logic br, input logic [15:0] off,
                        input logic jp, input logic [25:0] tg);
        logic        e_red;
        logic [31:0] tgt;
        exp_t        e;
        stall = st; branch_taken = br; branch_offset = off; jump_en = jp; jump_target = tg;
        #1;
        e_red = m_vld && !st && (br || jp);
        chk("index", index, (st ? m_ipc : m_pc) & 32'hF);
        chk("redirect", 32'(redirect), 32'(e_red));
        if (st) begin
        end else if (e_red) begin
            tgt   = jp ? {6'd0, tg} : m_ipc + 32'd1 + {{16{off[15]}}, off};
            m_ipc = m_pc;
            m_vld = 1'b0;
            m_pc  = tgt;
        end else begin
            m_ipc = m_pc;
            m_vld = 1'b1;
            m_pc  = m_pc + 32'd1;
            m_cnt = m_cnt + 32'd1;
        end
        sbq.push_back('{ipc: m_ipc, vld: m_vld, cnt: m_cnt});
        @(posedge clk); #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk("instr_pc", instr_pc, e.ipc);
            chk("instr_valid", 32'(instr_valid), 32'(e.vld));
            chk("fetch_count", fetch_count, e.cnt);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 1'b0, 26'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_cnt", fetch_count, 32'd0);
        chk("rst_index", index, 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        // that edge was the first active edge; account for it in the model
        m_ipc = m_pc; m_vld = 1'b1; m_pc = m_pc + 32'd1; m_cnt = m_cnt + 32'd1;
        chk("first_ipc", instr_pc, 32'd0);
        chk("first_valid", 32'(instr_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        stall = 0; branch_taken = 0; branch_offset = 0; jump_en = 0; jump_target = 0;
        rst_n = 1'b1;
        #2;
        do_reset();

        // free-running: 16 more fetches after the first gives instr_pc 1..16
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 16'd0, 1'b0, 26'd0);
            chk("seq_ipc", instr_pc, 32'(i));
        end
        chk("seq_cnt17", fetch_count, 32'd17);
        chk("seq_index_wrap", index, 32'd1);

        // taken branch at instr_pc=5, offset 1
        do_reset();
        run(5);
        chk("br_at5", instr_pc, 32'd5);
        step(1'b0, 1'b1, 16'd1, 1'b0, 26'd0);
        chk("br_bubble", 32'(instr_valid), 32'd0);
        chk("br_index", index, 32'd7);
        run(1);
        chk("br_tgt", instr_pc, 32'd7);
        chk("br_tgt_vld", 32'(instr_valid), 32'd1);

        // jump at instr_pc=8 to 0, then jump beats simultaneous branch
        run(1);
        chk("jp_at8", instr_pc, 32'd8);
        step(1'b0, 1'b0, 16'd0, 1'b1, 26'd0);
        chk("jp_bubble", 32'(instr_valid), 32'd0);
        run(1);
        chk("jp_tgt0", instr_pc, 32'd0);
        step(1'b0, 1'b1, 16'd4, 1'b1, 26'd3);
        run(1);
        chk("jp_wins", instr_pc, 32'd3);

        // stall with pending branch at instr_pc=2
        do_reset();
        run(2);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 16'd5, 1'b0, 26'd0);
            chk("stl_index", index, 32'd2);
            chk("stl_redirect", 32'(redirect), 32'd0);
            chk("stl_ipc", instr_pc, 32'd2);
            chk("stl_cnt", fetch_count, 32'd3);
        end
        step(1'b0, 1'b1, 16'd5, 1'b0, 26'd0);
        chk("stl_bubble", 32'(instr_valid), 32'd0);
        // branch request during the bubble is ignored
        step(1'b0, 1'b1, 16'd10, 1'b0, 26'd0);
        chk("bub_ignore_ipc", instr_pc, 32'd8);
        chk("bub_ignore_vld", 32'(instr_valid), 32'd1);

        // backward branch: 8 + 1 - 3 = 6
        step(1'b0, 1'b1, 16'hFFFD, 1'b0, 26'd0);
        run(1);
        chk("br_back", instr_pc, 32'd6);

        // asynchronous reset mid-cycle with pc=9
        run(2);
        chk("pre_rst_ipc", instr_pc, 32'd8);
        branch_taken = 1'b1;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_ipc", instr_pc, 32'd0);
        chk("arst_cnt", fetch_count, 32'd0);
        chk("arst_index", index, 32'd0);
        chk("arst_redirect", 32'(redirect), 32'd0);
        branch_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_ipc = m_pc; m_vld = 1'b1; m_pc = m_pc + 32'd1; m_cnt = m_cnt + 32'd1;
        chk("arst_first_ipc", instr_pc, 32'd0);
        chk("arst_first_vld", 32'(instr_valid), 32'd1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) == 0, ($urandom % 3) == 0, 16'($urandom),
                 ($urandom % 5) == 0, 26'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-sequencing stage sitting directly upstream of the instruction ROM. Drives the ROM's word `index` and tracks which PC the ROM's registered `InstrReg` output currently holds. Applies branch and jump redirects reported by decode, squashing the one wrong-path fetch. Re-presents the held instruction's index during decode stalls, since the ROM has no read enable.

## Interface
- `PC_W`, 32: PC / index width.
- `ROM_DEPTH`, 16: ROM words; power of two; the index wraps modulo this value.
- `RESET_PC`, 0: PC loaded on reset.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `stall` in 1: decode hold request.
- `branch_taken` in 1: decode resolved a taken branch for the instruction in `InstrReg`.
- `branch_offset` in 16: signed word offset (beq immediate).
- `jump_en` in 1: decode has a jump in `InstrReg`.
- `jump_target` in 26: word-index jump target.
- `index` out PC_W: ROM word address (combinational).
- `instr_valid` out 1: `InstrReg` holds a valid, non-squashed instruction.
- `instr_pc` out PC_W: PC of the instruction in `InstrReg`.
- `redirect` out 1: redirect accepted this cycle (combinational).
- `fetch_count` out 32: count of valid instructions delivered.

## Operation
- State:
  - `pc`: next fetch address.
  - `instr_pc`.
  - `instr_valid`.
  - `fetch_count`.
- `index` = (`stall` ? `instr_pc` : `pc`) mod `ROM_DEPTH`, zero-extended to PC_W.
- `redirect` = `instr_valid` & !`stall` & (`branch_taken` | `jump_en`).
- Branch target = `instr_pc` + 1 + sign_ext(`branch_offset`), computed in PC_W bits and wrapping modulo 2^PC_W.
- Jump target = zero_ext(`jump_target`).
- Next-state priority, highest first:
  1. `stall`: `pc`, `instr_pc`, `instr_valid` and `fetch_count` all hold. The ROM re-reads `instr_pc`, so `InstrReg` is unchanged. `branch_taken`/`jump_en` are ignored; decode keeps them asserted until `stall` drops.
  2. Redirect with `jump_en`: `pc` ← jump target. `instr_valid` ← 0, squashing the sequential word the ROM latches at this edge. `instr_pc` ← old `pc`. Jump wins over a simultaneous `branch_taken`.
  3. Redirect with `branch_taken`: same as above, using the branch target.
  4. Normal: `instr_pc` ← `pc`, `instr_valid` ← 1, `pc` ← `pc` + 1, `fetch_count` ← `fetch_count` + 1.
- `branch_taken`/`jump_en` while `instr_valid`=0 are ignored (no redirect).
- `fetch_count` wraps at 2^32.
- `pc` itself is not reduced modulo `ROM_DEPTH`; only `index` is. `instr_pc` therefore reports the unreduced PC.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - `pc`=RESET_PC, `instr_pc`=0, `instr_valid`=0, `fetch_count`=0.
  - `index`=RESET_PC mod ROM_DEPTH; `redirect`=0.
- First rising edge with `rst_n`=1: ROM latches word RESET_PC. `instr_valid`=1, `instr_pc`=RESET_PC, `pc`=RESET_PC+1.
- Fetch latency: 1 cycle from `index` to `InstrReg`. `instr_pc`/`instr_valid` update on the same edge as `InstrReg` and stay aligned with it.
- Taken branch or jump costs 1 bubble cycle (`instr_valid`=0). The target instruction is valid on the second edge after the redirect cycle.
- Wrap-around: a `pc` of ROM_DEPTH-1 followed by ROM_DEPTH gives `index` 15 then 0 with the default depth.
- Stall entry/exit is glitch-free. On the first non-stall cycle, `index` returns to `pc`.
- Reset asserted mid-operation: all state returns to reset values asynchronously, discarding any pending redirect. Sequence restarts as above.

## Test plan
- Reset then 17 free-running cycles -> `instr_pc` 0,1,…,15,16. `index` goes 1..15 then 0. `instr_valid`=1 throughout. `fetch_count`=17.
- `instr_pc`=5, `branch_taken`=1, `branch_offset`=1 -> `redirect`=1 for one cycle. Next cycle `instr_valid`=0 and `index`=7. Following cycle `instr_pc`=7, valid (word 6 never valid).
- `instr_pc`=8, `jump_en`=1, `jump_target`=0 -> one bubble, then `instr_pc`=0 valid. Also `jump_en`=1 with target 3 together with `branch_taken`=1 and offset 4 -> next valid `instr_pc`=3.
- `stall` held 3 cycles at `instr_pc`=2 with `branch_taken`=1 -> `index`=2, `instr_pc`=2, `redirect`=0 and `fetch_count` frozen. After release, the branch redirects.
- `branch_taken`=1 while `instr_valid`=0 (bubble) -> ignored; sequential fetch continues.
- `rst_n` pulsed low mid-cycle while `pc`=9 -> outputs immediately at reset values. After release, `instr_pc`=0 on the first edge.
